// File: rtl/ps2_scancode_receiver_if.sv
// Consumer-side handshake bundle of the PS/2 scan-code receiver.
// The receiver holds a decoded code with ready until the consumer pulses read_fin.
interface ps2_scancode_receiver_if;
  logic       read_fin;
  logic       ready;
  logic [7:0] code;
  logic       extended;
  logic       released;
  logic       overrun;
  logic [7:0] err_cnt;

  modport master (
    input  read_fin,
    output ready, code, extended, released, overrun, err_cnt
  );

  modport slave (
    output read_fin,
    input  ready, code, extended, released, overrun, err_cnt
  );
endinterface

// File: rtl/ps2_scancode_receiver.sv
// PS/2 device-to-host receiver: synchronizes and deglitches the PS/2 clock, deframes
// 11-bit frames, strips E0/F0 prefixes and holds each resulting scan code for the consumer.
module ps2_scancode_receiver #(
  parameter int unsigned FILTER_LEN     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic clock,
  input  logic reset,
  input  logic ps2_clock,
  input  logic ps2_data,
  ps2_scancode_receiver_if.master bus
);

  localparam int unsigned FILT_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam int unsigned TMO_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [FILT_W-1:0] FILT_LAST = FILT_W'(FILTER_LEN - 1);
  localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0] PREFIX_EXT = 8'hE0;
  localparam logic [7:0] PREFIX_BRK = 8'hF0;

  typedef enum logic [1:0] {IDLE, RECV, CHECK} state_t;

  state_t            state, next_state;
  logic              clk_s1, clk_s2, dat_s1, dat_s2;
  logic              clk_filt;
  logic [FILT_W-1:0] filt_cnt;
  logic              sample_ev, sample_bit;
  logic [3:0]        bit_cnt;
  logic [9:0]        shreg;
  logic [TMO_W-1:0]  tmo_cnt;
  logic              ready_q, ext_q, rel_q, ovr_q;
  logic [7:0]        code_q, err_q;
  logic              ext_pend, brk_pend;
  logic              shift_en_c, check_c, frame_ok_c;
  logic [7:0]        byte_c;

  // Synchronizers, clock deglitch filter and falling-edge sample strobe
  always_ff @(posedge clock) begin
    if (reset) begin
      clk_s1     <= 1'b1;
      clk_s2     <= 1'b1;
      dat_s1     <= 1'b1;
      dat_s2     <= 1'b1;
      clk_filt   <= 1'b1;
      filt_cnt   <= '0;
      sample_ev  <= 1'b0;
      sample_bit <= 1'b1;
    end else begin
      clk_s1    <= ps2_clock;
      clk_s2    <= clk_s1;
      dat_s1    <= ps2_data;
      dat_s2    <= dat_s1;
      sample_ev <= 1'b0;
      if (clk_s2 == clk_filt) begin
        filt_cnt <= '0;
      end else if (filt_cnt == FILT_LAST) begin
        clk_filt <= clk_s2;
        filt_cnt <= '0;
        if (!clk_s2) begin
          sample_ev  <= 1'b1;
          sample_bit <= dat_s2;
        end
      end else begin
        filt_cnt <= filt_cnt + FILT_W'(1);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    shift_en_c = 1'b0;
    check_c    = 1'b0;
    case (state)
      IDLE: if (sample_ev && !sample_bit) next_state = RECV;
      RECV: begin
        if (sample_ev) begin
          shift_en_c = 1'b1;
          if (bit_cnt == 4'd9) next_state = CHECK;
        end else if (tmo_cnt == TMO_LAST) begin
          next_state = IDLE;
        end
      end
      CHECK: begin
        check_c    = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // shreg[7:0] data LSB first, shreg[8] parity, shreg[9] stop once ten bits are in
  assign byte_c     = shreg[7:0];
  assign frame_ok_c = (^shreg[8:0]) & shreg[9];

  always_ff @(posedge clock) begin
    if (reset) begin
      bit_cnt  <= '0;
      shreg    <= '0;
      tmo_cnt  <= '0;
      ready_q  <= 1'b0;
      code_q   <= '0;
      ext_q    <= 1'b0;
      rel_q    <= 1'b0;
      ovr_q    <= 1'b0;
      err_q    <= '0;
      ext_pend <= 1'b0;
      brk_pend <= 1'b0;
    end else begin
      if (state == IDLE)   bit_cnt <= '0;
      else if (shift_en_c) bit_cnt <= bit_cnt + 4'd1;
      if (shift_en_c) shreg <= {sample_bit, shreg[9:1]};
      if (state != RECV || sample_ev) tmo_cnt <= '0;
      else                            tmo_cnt <= tmo_cnt + TMO_W'(1);

      if (bus.read_fin && ready_q) ready_q <= 1'b0;

      // A load in the CHECK cycle overrides a concurrent read_fin clear
      if (check_c) begin
        if (!frame_ok_c) begin
          if (err_q != 8'hFF) err_q <= err_q + 8'd1;
          ext_pend <= 1'b0;
          brk_pend <= 1'b0;
        end else if (byte_c == PREFIX_EXT) begin
          ext_pend <= 1'b1;
        end else if (byte_c == PREFIX_BRK) begin
          brk_pend <= 1'b1;
        end else begin
          ext_pend <= 1'b0;
          brk_pend <= 1'b0;
          if (!ready_q || bus.read_fin) begin
            code_q  <= byte_c;
            ext_q   <= ext_pend;
            rel_q   <= brk_pend;
            ready_q <= 1'b1;
          end else begin
            ovr_q <= 1'b1;
          end
        end
      end
    end
  end

  assign bus.ready    = ready_q;
  assign bus.code     = code_q;
  assign bus.extended = ext_q;
  assign bus.released = rel_q;
  assign bus.overrun  = ovr_q;
  assign bus.err_cnt  = err_q;

endmodule
